// File: rtl/timing_gen_pkg.sv
// Shared types for the multi-channel timing generator: register select, register set, reset defaults.
// Field storage is TG_W_MAX bits wide, so PIX_W and LINE_W must not exceed it.
package timing_gen_pkg;

    localparam int TG_W_MAX = 16;

    typedef enum logic [1:0] {
        PIX_PERIOD = 2'd0,
        LINE_COUNT = 2'd1,
        LINE_PW    = 2'd2,
        FRAME_PW   = 2'd3
    } cfg_sel_e;

    typedef struct packed {
        logic [TG_W_MAX-1:0] pix_period;
        logic [TG_W_MAX-1:0] line_count;
        logic [TG_W_MAX-1:0] line_pw;
        logic [TG_W_MAX-1:0] frame_pw;
    } tg_regs_t;

    function automatic tg_regs_t tg_default_regs(input int pix_w, input int line_w);
        tg_regs_t r;
        r.pix_period = TG_W_MAX'((32'd1 << pix_w) - 32'd1);
        r.line_count = TG_W_MAX'((32'd1 << line_w) - 32'd1);
        r.line_pw    = TG_W_MAX'(1);
        r.frame_pw   = TG_W_MAX'(1);
        return r;
    endfunction

endpackage

// File: rtl/timing_gen_channel.sv
// One timing channel: shadow/active register sets, pixel/line counters and registered sync outputs.
// Counting starts one cycle after en rises (en_q), so outputs appear two edges after en is sampled.
module timing_gen_channel
    import timing_gen_pkg::*;
#(
    parameter int PIX_W  = 12,
    parameter int LINE_W = 12,
    parameter int DATA_W = 12
) (
    input  logic              clk_gen,
    input  logic              reset,
    input  logic              en,
    input  logic              wr_en,
    input  cfg_sel_e          wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              lock,
    output logic              last_pix,
    output logic              sync_line,
    output logic              sync_frame,
    output logic              frame_start
);

    localparam tg_regs_t REG_RST = tg_default_regs(PIX_W, LINE_W);

    tg_regs_t            shadow_q;
    tg_regs_t            active_q;
    logic [PIX_W-1:0]    pix_cnt;
    logic [LINE_W-1:0]   line_cnt;
    logic                en_q;

    logic [TG_W_MAX-1:0] pix_ext;
    logic [TG_W_MAX-1:0] line_ext;
    logic [TG_W_MAX-1:0] pix_last;
    logic [TG_W_MAX-1:0] line_last;
    logic [TG_W_MAX-1:0] wr_val;
    logic                running;
    logic                pix_wrap;
    logic                force_restart;
    logic                xfer;

    always_comb begin
        pix_ext   = TG_W_MAX'(pix_cnt);
        line_ext  = TG_W_MAX'(line_cnt);
        // A programmed period of 0 behaves as 1.
        pix_last  = (active_q.pix_period == '0) ? '0 : active_q.pix_period - TG_W_MAX'(1);
        line_last = (active_q.line_count == '0) ? '0 : active_q.line_count - TG_W_MAX'(1);

        running       = en && en_q;
        pix_wrap      = running && (pix_ext == pix_last);
        last_pix      = pix_wrap && (line_ext == line_last);
        force_restart = en && lock;
        xfer          = !en || last_pix || force_restart;

        // Line-axis fields are compared against pix_cnt, frame-axis fields against line_cnt.
        if (wr_sel == PIX_PERIOD || wr_sel == LINE_PW)
            wr_val = TG_W_MAX'(wr_data[PIX_W-1:0]);
        else
            wr_val = TG_W_MAX'(wr_data[LINE_W-1:0]);
    end

    always_ff @(posedge clk_gen) begin
        if (reset) begin
            shadow_q    <= REG_RST;
            active_q    <= REG_RST;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            en_q        <= 1'b0;
            sync_line   <= 1'b0;
            sync_frame  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            en_q <= en;

            // Transfer samples the old shadow; a write on the same edge waits for the next boundary.
            if (xfer)
                active_q <= shadow_q;

            if (wr_en) begin
                case (wr_sel)
                    PIX_PERIOD: shadow_q.pix_period <= wr_val;
                    LINE_COUNT: shadow_q.line_count <= wr_val;
                    LINE_PW:    shadow_q.line_pw    <= wr_val;
                    FRAME_PW:   shadow_q.frame_pw   <= wr_val;
                    default:    ;
                endcase
            end

            sync_line   <= running && (pix_ext < active_q.line_pw);
            sync_frame  <= running && (line_ext < active_q.frame_pw);
            frame_start <= running && (pix_cnt == '0) && (line_cnt == '0);

            if (!running || last_pix || force_restart) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
            end else if (pix_wrap) begin
                pix_cnt  <= '0;
                line_cnt <= line_cnt + LINE_W'(1);
            end else begin
                pix_cnt  <= pix_cnt + PIX_W'(1);
            end
        end
    end

endmodule

// File: rtl/timing_generator_mc.sv
// Multi-channel line/frame sync generator: config decode, ready muxing and optional frame lock.
// Define TG_FRAME_LOCK_EN to slave every enabled channel's frame start to channel 0.
module timing_generator_mc
    import timing_gen_pkg::*;
#(
    parameter  int N_CH   = 2,
    parameter  int PIX_W  = 12,
    parameter  int LINE_W = 12,
    localparam int DATA_W = (PIX_W > LINE_W) ? PIX_W : LINE_W,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_gen,
    input  logic              reset,
    input  logic [N_CH-1:0]   en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_sel,
    input  logic [DATA_W-1:0] cfg_data,
    output logic [N_CH-1:0]   sync_line,
    output logic [N_CH-1:0]   sync_frame,
    output logic [N_CH-1:0]   frame_start
);

`ifdef TG_FRAME_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic [N_CH-1:0] last_pix;
    logic [N_CH-1:0] wr_en;
    logic [N_CH-1:0] lock;
    logic            en0_q;

    always_ff @(posedge clk_gen) begin
        if (reset)
            en0_q <= 1'b0;
        else
            en0_q <= en[0];
    end

    // Out-of-range cfg_ch never matches, so such writes are accepted and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < N_CH; i++)
            if (cfg_ch == CH_W'(i) && last_pix[i])
                cfg_ready = 1'b0;
    end

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < N_CH; i++)
            wr_en[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end

    // Fire on the edge where channel 0 enters pixel 0/line 0, so followers start on the same cycle.
    always_comb begin
        lock = '0;
        for (int i = 1; i < N_CH; i++)
            lock[i] = LOCK_EN && en[0] && (!en0_q || last_pix[0]);
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timing_gen_channel #(
            .PIX_W  (PIX_W),
            .LINE_W (LINE_W),
            .DATA_W (DATA_W)
        ) u_ch (
            .clk_gen     (clk_gen),
            .reset       (reset),
            .en          (en[i]),
            .wr_en       (wr_en[i]),
            .wr_sel      (cfg_sel_e'(cfg_sel)),
            .wr_data     (cfg_data),
            .lock        (lock[i]),
            .last_pix    (last_pix[i]),
            .sync_line   (sync_line[i]),
            .sync_frame  (sync_frame[i]),
            .frame_start (frame_start[i])
        );
    end

endmodule

// File: tb/tb_timing_generator_mc.sv
// Bench for timing_generator_mc: frame-position reference model checked every cycle, plus table-driven
// per-frame measurements and directed sequences for boundary writes, channel offset, en drop and reset.
module tb_timing_generator_mc;

    localparam int NC = 3;
`ifdef TG_FRAME_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic          clk_gen = 1'b0;
    logic          reset;
    logic [NC-1:0] en;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [1:0]    cfg_sel;
    logic [11:0]   cfg_data;
    logic [NC-1:0] sync_line;
    logic [NC-1:0] sync_frame;
    logic [NC-1:0] frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_gen = ~clk_gen;

    timing_generator_mc #(.N_CH(NC), .PIX_W(12), .LINE_W(12)) dut (
        .clk_gen     (clk_gen),
        .reset       (reset),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .sync_line   (sync_line),
        .sync_frame  (sync_frame),
        .frame_start (frame_start)
    );

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model: position t inside the frame, pix = t%pp, line = t/pp
    int            act[NC][4];
    int            shd[NC][4];
    bit            run[NC];
    int            t[NC];
    logic [NC-1:0] x_sl, x_sf, x_fs;
    bit            model_live = 0;

    function automatic int m_pp(input int c);
        return (act[c][0] == 0) ? 1 : act[c][0];
    endfunction
    function automatic int m_lc(input int c);
        return (act[c][1] == 0) ? 1 : act[c][1];
    endfunction
    function automatic bit m_last(input int c);
        return en[c] && run[c] && (t[c] == m_pp(c) * m_lc(c) - 1);
    endfunction
    function automatic bit m_ready();
        if (int'(cfg_ch) < NC) return !m_last(int'(cfg_ch));
        return 1'b1;
    endfunction

    task automatic model_step();
        bit lastv[NC];
        bit acc, lead, running, lk;
        int pp;
        if (reset) begin
            for (int c = 0; c < NC; c++) begin
                act[c] = '{4095, 4095, 1, 1};
                shd[c] = '{4095, 4095, 1, 1};
                run[c] = 0;
                t[c]   = 0;
            end
            x_sl = '0; x_sf = '0; x_fs = '0;
            return;
        end
        for (int c = 0; c < NC; c++) lastv[c] = m_last(c);
        acc  = cfg_valid && m_ready();
        lead = en[0] && (!run[0] || lastv[0]);
        for (int c = 0; c < NC; c++) begin
            running = en[c] && run[c];
            pp      = m_pp(c);
            x_sl[c] = running && ((t[c] % pp) < act[c][2]);
            x_sf[c] = running && ((t[c] / pp) < act[c][3]);
            x_fs[c] = running && (t[c] == 0);
            lk      = LOCK && (c != 0) && en[c] && lead;
            if (!running || lastv[c] || lk) t[c] = 0;
            else                            t[c]++;
            if (!en[c] || lastv[c] || lk) act[c] = shd[c];
            if (acc && int'(cfg_ch) == c) shd[c][cfg_sel] = int'(cfg_data);
            run[c] = en[c];
        end
    endtask

    always @(posedge clk_gen) begin
        model_step();
        model_live = 1;
        #1;
        check("sync_line",   sync_line,   x_sl);
        check("sync_frame",  sync_frame,  x_sf);
        check("frame_start", frame_start, x_fs);
        check("cfg_ready",   cfg_ready,   m_ready());
    end

    // ---------------- stimulus helpers (inputs change only at negedge)
    task automatic cfg_write(input int ch, input int sel, input int data);
        bit ok = 0;
        @(negedge clk_gen);
        cfg_valid = 1; cfg_ch = 2'(ch); cfg_sel = 2'(sel); cfg_data = 12'(data);
        for (int i = 0; i < 200 && !ok; i++) begin
            #1 ok = cfg_ready;
            @(negedge clk_gen);
        end
        cfg_valid = 0;
        if (!ok) check("cfg_write_timeout", 0, 1);
    endtask

    task automatic program_ch(input int ch, input int pp, input int lc, input int lw, input int fw);
        @(negedge clk_gen);
        en[ch] = 0;
        cfg_write(ch, 0, pp);
        cfg_write(ch, 1, lc);
        cfg_write(ch, 2, lw);
        cfg_write(ch, 3, fw);
        repeat (2) @(negedge clk_gen);
    endtask

    task automatic wait_fs(input int ch, input int limit);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk_gen);
            seen = frame_start[ch];
        end
        if (!seen) check("wait_frame_start_timeout", 0, 1);
    endtask

    typedef struct {
        int pp, lc, lw, fw;
        int exp_lh, exp_fh, exp_per;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int lh, fh, fc, lows, low_at, d;
        bit found;

        tbl[0] = '{10, 4,  2, 1,  8, 10, 40};
        tbl[1] = '{10, 4,  0, 1,  0, 10, 40};
        tbl[2] = '{10, 4, 12, 1, 40, 10, 40};
        tbl[3] = '{ 6, 3,  1, 5,  3, 18, 18};
        tbl[4] = '{ 0, 0,  1, 1,  1,  1,  1};
        tbl[5] = '{ 5, 2,  3, 0,  6,  0, 10};

        reset = 1; en = '0; cfg_valid = 0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
        repeat (3) @(negedge clk_gen);
        reset = 0;
        @(negedge clk_gen);
        check("reset_cfg_ready", cfg_ready, 1);
        check("reset_outputs", {sync_line, sync_frame, frame_start}, 0);

        // table: one full frame measured from frame_start on channel 0
        for (int v = 0; v < 6; v++) begin
            program_ch(0, tbl[v].pp, tbl[v].lc, tbl[v].lw, tbl[v].fw);
            en[0] = 1;
            wait_fs(0, 20);
            lh = 0; fh = 0; fc = 0;
            for (int k = 0; k < tbl[v].exp_per; k++) begin
                lh += int'(sync_line[0]); fh += int'(sync_frame[0]); fc += int'(frame_start[0]);
                @(negedge clk_gen);
            end
            check($sformatf("tbl%0d_line_hi", v), lh, tbl[v].exp_lh);
            check($sformatf("tbl%0d_frame_hi", v), fh, tbl[v].exp_fh);
            check($sformatf("tbl%0d_fs_in_frame", v), fc, 1);
            check($sformatf("tbl%0d_fs_period", v), frame_start[0], 1);
        end

        // mid-frame pix_period write: old frame finishes at 10, next runs at 6
        program_ch(0, 10, 4, 2, 1);
        en[0] = 1;
        wait_fs(0, 20);
        lows = 0; low_at = -1; fc = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 5) begin cfg_valid = 1; cfg_ch = 0; cfg_sel = 0; cfg_data = 12'd6; end
            if (k == 6) cfg_valid = 0;
            #1;
            if (!cfg_ready) begin lows++; low_at = k; end
            if (k > 0) fc += int'(frame_start[0]);
            @(negedge clk_gen);
        end
        check("midwrite_ready_low_cycles", lows, 1);
        check("midwrite_ready_low_at", low_at, 38);
        check("midwrite_old_period", frame_start[0], 1);
        check("midwrite_no_early_fs", fc, 0);
        fc = 0;
        for (int k = 1; k < 24; k++) begin
            @(negedge clk_gen);
            fc += int'(frame_start[0]);
        end
        @(negedge clk_gen);
        check("midwrite_new_period", frame_start[0], 1);
        check("midwrite_no_early_fs2", fc, 0);

        // ch1 started 7 cycles after ch0: locked or offset
        program_ch(0, 10, 4, 2, 1);
        program_ch(1, 10, 4, 2, 1);
        @(negedge clk_gen);
        en[0] = 1;
        repeat (7) @(negedge clk_gen);
        en[1] = 1;
        repeat (100) @(negedge clk_gen);
        wait_fs(0, 60);
        d = 0; found = frame_start[1];
        while (!found && d < 40) begin
            @(negedge clk_gen);
            d++;
            found = frame_start[1];
        end
        check("ch1_offset", d, LOCK ? 0 : 7);

        // drop en[1] at pixel 0, then re-enable
        wait_fs(1, 60);
        en[1] = 0;
        @(negedge clk_gen);
        check("en_drop_outputs", {sync_line[1], sync_frame[1], frame_start[1]}, 0);
        en[1] = 1;
        @(negedge clk_gen);
        check("reenable_wait", frame_start[1], 0);
        @(negedge clk_gen);
        check("reenable_fs", frame_start[1], 1);
        check("reenable_line", sync_line[1], 1);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_gen);
            cfg_valid = 0;
            if ($urandom_range(0, 3) == 0) begin
                cfg_valid = 1;
                cfg_ch    = 2'($urandom_range(0, 3));
                cfg_sel   = 2'($urandom_range(0, 3));
                cfg_data  = (cfg_sel < 2) ? 12'($urandom_range(0, 12)) : 12'($urandom_range(0, 14));
            end
            for (int c = 0; c < NC; c++)
                if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
        end
        @(negedge clk_gen);
        cfg_valid = 0;

        // reset mid-frame with a pending shadow write: defaults must return
        program_ch(0, 10, 4, 2, 1);
        en = 3'b001;
        repeat (13) @(negedge clk_gen);
        cfg_write(0, 2, 3);
        repeat (3) @(negedge clk_gen);
        reset = 1;
        @(negedge clk_gen);
        check("reset_mid_outputs", {sync_line, sync_frame, frame_start}, 0);
        check("reset_mid_ready", cfg_ready, 1);
        reset = 0;
        wait_fs(0, 20);
        lh = 0; fh = 0;
        for (int k = 0; k < 4095; k++) begin
            lh += int'(sync_line[0]); fh += int'(sync_frame[0]);
            @(negedge clk_gen);
        end
        check("default_line_hi", lh, 1);
        check("default_frame_hi", fh, 4095);
        check("default_line_repeat", sync_line[0], 1);
        check("default_frame_low_line1", sync_frame[0], 0);
        check("default_no_fs_line1", frame_start[0], 0);

        @(negedge clk_gen);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/timing_generator_mc.md
# timing_generator_mc

- Multi-channel, runtime-programmable line/frame sync generator. It replaces the fixed two-domain (sensor/interface) timing generator.
- Each of `N_CH` channels runs its own pixel and line counters and produces line- and frame-sync pulses. Period and pulse widths for each channel are set through a valid/ready config port.
- New values are double-buffered and take effect only at that channel's frame boundary, so a frame is never torn.
- Sits at the top of the video path and drives the sensor and the downstream interface from one clock.

## Interface
- `N_CH`, 2: number of independent timing channels, 1..8.
- `PIX_W`, 12: pixel-counter width (line period range).
- `LINE_W`, 12: line-counter width (frame length range).
- `DATA_W`, max(PIX_W, LINE_W): config data width (derived localparam, not overridden).
- `clk_gen`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `en`  in  N_CH  per-channel run enable.
- `cfg_valid`  in  1  config write request.
- `cfg_ready`  out  1  config write can be accepted this cycle.
- `cfg_ch`  in  max(1,$clog2(N_CH))  target channel.
- `cfg_sel`  in  2  register select: 0 pix_period, 1 line_count, 2 line_pw, 3 frame_pw.
- `cfg_data`  in  DATA_W  value; upper bits are ignored for the narrower fields.
- `sync_line`  out  N_CH  line-sync pulse per channel.
- `sync_frame`  out  N_CH  frame-sync pulse per channel.
- `frame_start`  out  N_CH  one-cycle strobe, first pixel of line 0.

## Operation
- Per channel there is an active register set and a shadow register set for pix_period, line_count, line_pw and frame_pw.
- A config write lands in the shadow set when `cfg_valid && cfg_ready`. Out-of-range `cfg_ch` (≥N_CH) is accepted and discarded.
- Shadow→active transfer happens:
  - in the last-pixel-of-last-line cycle of an enabled channel, or
  - on every cycle while that channel's `en`=0.
- Counters:
  - pix_cnt counts 0..pix_period-1.
  - line_cnt advances when pix_cnt wraps, and counts 0..line_count-1.
  - A pix_period or line_count of 0 is treated as 1.
- Outputs:
  - `sync_line` = pix_cnt < line_pw.
  - `sync_frame` = line_cnt < frame_pw; width is counted in whole lines.
  - pw=0 gives a constantly low output; pw ≥ period gives a constantly high output.
  - `frame_start` = pix_cnt==0 && line_cnt==0 && en.
- `en`=0: counters are held at 0 and all of that channel's outputs are 0.
- Dropping `en` mid-frame aborts immediately. Re-enabling restarts at pixel 0, line 0.
- `cfg_ready` is low only in the transfer cycle of the channel addressed by `cfg_ch` (enabled, last pixel of last line); it is high otherwise.

## Timing
- Reset values:
  - counters 0; outputs `sync_line`/`sync_frame`/`frame_start` = 0; `cfg_ready`=1 in the cycle after reset.
  - active and shadow registers: pix_period = 2^PIX_W-1, line_count = 2^LINE_W-1, line_pw = 1, frame_pw = 1.
- All outputs are registered, one cycle after the counter state that produces them. With `en` sampled high at edge k, `frame_start`, `sync_line` and `sync_frame` (for nonzero pw) are first high after edge k+1.
- Shadow values written in cycle t apply from the first pixel of the next frame. If t is the transfer cycle itself, the write is blocked by `cfg_ready`=0 and waits for the following frame.
- Reset asserted mid-frame: everything returns to reset values at the next edge and pending shadow writes are lost.

## Configuration
- Macro: `TG_FRAME_LOCK_EN`.
- Defined: channel 0's frame_start forces every other enabled channel's counters to pixel 0, line 0 on the same edge. Shadow→active transfer happens on that edge as well. Channels thereby stay frame-aligned to channel 0.
- Undefined: channels are fully free-running and independent.

## Structure
- Package `timing_gen_pkg`:
  - `cfg_sel_e` enum (PIX_PERIOD, LINE_COUNT, LINE_PW, FRAME_PW).
  - struct `tg_regs_t` holding the four fields.
  - reset-default function of PIX_W/LINE_W.
- Sub-module `timing_gen_channel`, instantiated N_CH times by a generate loop. It holds the shadow/active registers, counters and output flops, and drives a `last_pix` flag used for `cfg_ready`.
- The top holds only config decode, ready muxing and the lock fan-out.

## Test plan
- Reset, then en[0]=1 with defaults → `sync_line` high 1 cycle every 4095, `frame_start` period 4095×4095, `cfg_ready`=1.
- Program ch0: pix_period=10, line_pw=2, line_count=4, frame_pw=1.
  - Expect `sync_line` high 2 of every 10 cycles.
  - Expect `sync_frame` high 10 cycles of every 40.
  - Expect `frame_start` every 40 cycles.
- Mid-frame write of pix_period=6 to a running ch0 → the current frame completes at period 10, the next frame runs at 6, and `cfg_ready`=0 exactly in the boundary cycle.
- line_pw=0 → `sync_line` never high. line_pw=12 with pix_period=10 → `sync_line` constantly high while enabled.
- ch1 enabled 7 cycles after ch0, both set to period 10 × 4 lines:
  - With `TG_FRAME_LOCK_EN` defined, ch1's `frame_start` coincides with ch0's from the second ch0 frame on.
  - Without it, the 7-cycle offset persists.
- Drop en[1] mid-line, then reassert → outputs go 0 the next cycle, then restart at pixel 0, line 0 with `frame_start`. Assert reset mid-frame → all outputs return to 0 and the registers return to defaults.
